// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU sprite pipeline.
package ppu_pkg;

    // Byte offsets within a 4-byte OAM entry
    localparam logic [1:0] OAM_Y    = 2'd0;
    localparam logic [1:0] OAM_TILE = 2'd1;
    localparam logic [1:0] OAM_ATTR = 2'd2;
    localparam logic [1:0] OAM_X    = 2'd3;

    localparam logic [8:0] SPRITE_H_8  = 9'd8;
    localparam logic [8:0] SPRITE_H_16 = 9'd16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_Y,
        S_RD_X,
        S_CHK,
        S_RD_T,
        S_RD_A,
        S_STORE,
        S_NEXT,
        S_DONE
    } sprite_eval_state_t;

    typedef struct packed {
        logic       on_tile;
        logic [7:0] tile_num;
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] attr;
    } sprite_slot_t;

endpackage

// File: rtl/sprite_overlap_check.sv
// Combinational test of whether one sprite overlaps the 8-pixel span at (curr_row, curr_col).
module sprite_overlap_check
    import ppu_pkg::*;
(
    input  logic [8:0] curr_row,
    input  logic [8:0] curr_col,
    input  logic [7:0] y,
    input  logic [7:0] x,
    input  logic       tall,
    output logic       hit
);

    logic [8:0]        height;
    logic [8:0]        row_diff;
    logic signed [9:0] c;
    logic signed [9:0] xs;
    logic              row_hit;
    logic              col_hit;

    always_comb begin
        height   = tall ? SPRITE_H_16 : SPRITE_H_8;
        row_diff = curr_row - {1'b0, y};
        row_hit  = (y < 8'd240) && (curr_row >= {1'b0, y}) && (row_diff < height);
        // curr_col is signed so spans hanging off the left edge still match
        c        = {curr_col[8], curr_col};
        xs       = {2'b00, x};
        col_hit  = (xs <= c + 10'sd7) && (xs + 10'sd7 >= c);
        hit      = row_hit && col_hit;
    end

endmodule

// File: rtl/ppu_sprite_eval_fsm.sv
// Scans OAM for sprites overlapping the current span and commits up to two slots plus overflow.
module ppu_sprite_eval_fsm
    import ppu_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 64,
    parameter int unsigned MAX_SLOTS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] curr_row,
    input  logic [8:0] curr_col,
    input  logic [7:0] ppu_ctrl1,
    input  logic [7:0] ppu_ctrl2,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_data,
    output logic       sprite_0_on_tile,
    output logic [7:0] sprite_0_tile_num,
    output logic [7:0] sprite_0_row,
    output logic [7:0] sprite_0_col,
    output logic [7:0] sprite_0_attr,
    output logic       sprite_1_on_tile,
    output logic [7:0] sprite_1_tile_num,
    output logic [7:0] sprite_1_row,
    output logic [7:0] sprite_1_col,
    output logic [7:0] sprite_1_attr,
    output logic       sprite_overflow,
    output logic       busy
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_SPRITES - 1);
    localparam logic [1:0] SLOT_CNT = 2'(MAX_SLOTS);

    sprite_eval_state_t state;
    logic [5:0]         idx;
    logic [7:0]         spr_y;
    logic [7:0]         spr_x;
    logic [7:0]         spr_tile;
    logic [1:0]         hit_cnt;
    logic               stage_ovf;
    sprite_slot_t       stage_0;
    sprite_slot_t       stage_1;
    sprite_slot_t       out_0;
    sprite_slot_t       out_1;
    logic               hit;
    logic               unused_ctrl_bits;

    assign unused_ctrl_bits = ^{ppu_ctrl1[7:6], ppu_ctrl1[4:0], ppu_ctrl2[7:5], ppu_ctrl2[3:0]};

    // In S_CHK the X byte is still on oam_data, so it feeds the check directly
    sprite_overlap_check u_overlap (
        .curr_row (curr_row),
        .curr_col (curr_col),
        .y        (spr_y),
        .x        (oam_data),
        .tall     (ppu_ctrl1[5]),
        .hit      (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            oam_addr  <= '0;
            busy      <= 1'b0;
            spr_y     <= '0;
            spr_x     <= '0;
            spr_tile  <= '0;
            hit_cnt   <= '0;
            stage_ovf <= 1'b0;
            stage_0   <= '0;
            stage_1   <= '0;
            out_0     <= '0;
            out_1     <= '0;
            sprite_overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        stage_0   <= '0;
                        stage_1   <= '0;
                        stage_ovf <= 1'b0;
                        hit_cnt   <= '0;
                        idx       <= '0;
                        oam_addr  <= {6'd0, OAM_Y};
                        state     <= ppu_ctrl2[4] ? S_RD_Y : S_DONE;
                    end
                end
                S_RD_Y: begin
                    oam_addr <= {idx, OAM_X};
                    state    <= S_RD_X;
                end
                S_RD_X: begin
                    spr_y <= oam_data;
                    state <= S_CHK;
                end
                S_CHK: begin
                    spr_x <= oam_data;
                    if (hit) begin
                        if (hit_cnt < SLOT_CNT) begin
                            oam_addr <= {idx, OAM_TILE};
                            state    <= S_RD_T;
                        end else begin
                            stage_ovf <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_RD_T: begin
                    oam_addr <= {idx, OAM_ATTR};
                    state    <= S_RD_A;
                end
                S_RD_A: begin
                    spr_tile <= oam_data;
                    state    <= S_STORE;
                end
                S_STORE: begin
                    if (hit_cnt == 2'd0) begin
                        stage_0 <= '{on_tile: 1'b1, tile_num: spr_tile, row: spr_y,
                                     col: spr_x, attr: oam_data};
                    end else begin
                        stage_1 <= '{on_tile: 1'b1, tile_num: spr_tile, row: spr_y,
                                     col: spr_x, attr: oam_data};
                    end
                    hit_cnt <= hit_cnt + 2'd1;
                    state   <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx      <= idx + 6'd1;
                        oam_addr <= {idx + 6'd1, OAM_Y};
                        state    <= S_RD_Y;
                    end
                end
                S_DONE: begin
                    // Empty slots only clear on_tile; their other fields stay stale
                    if (stage_0.on_tile) out_0 <= stage_0;
                    else                 out_0.on_tile <= 1'b0;
                    if (stage_1.on_tile) out_1 <= stage_1;
                    else                 out_1.on_tile <= 1'b0;
                    sprite_overflow <= stage_ovf;
                    busy            <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign sprite_0_on_tile  = out_0.on_tile;
    assign sprite_0_tile_num = out_0.tile_num;
    assign sprite_0_row      = out_0.row;
    assign sprite_0_col      = out_0.col;
    assign sprite_0_attr     = out_0.attr;
    assign sprite_1_on_tile  = out_1.on_tile;
    assign sprite_1_tile_num = out_1.tile_num;
    assign sprite_1_row      = out_1.row;
    assign sprite_1_col      = out_1.col;
    assign sprite_1_attr     = out_1.attr;

endmodule
